// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers (write and read side).
package fifo_pkg;

  localparam int DEFAULT_ADDRSIZE = 4;
  localparam int FUNC_W           = 32;

  // Width-generic: callers zero-extend into FUNC_W bits and size-cast the result back down.
  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
    return b ^ (b >> 5'd1);
  endfunction

  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b[FUNC_W-1] = g[FUNC_W-1];
    for (int i = FUNC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus between the producer, the FIFO memory and the read-domain pointer.
// Optional woverflow signal is present when FIFO_OVERFLOW_FLAG_EN is defined.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) ();

  logic                winc;
  logic [ADDRSIZE:0]   wrptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
`ifdef FIFO_OVERFLOW_FLAG_EN
  logic                woverflow;
`endif

  modport slave (
    input  winc,
    input  wrptr,
    output waddr,
    output wptr,
    output wfull,
    output walmost_full,
`ifdef FIFO_OVERFLOW_FLAG_EN
    output woverflow,
`endif
    output wlevel
  );

  modport master (
    output winc,
    output wrptr,
    input  waddr,
    input  wptr,
    input  wfull,
    input  walmost_full,
`ifdef FIFO_OVERFLOW_FLAG_EN
    input  woverflow,
`endif
    input  wlevel
  );

endinterface

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer; synchronous active-low reset.
module fifo_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_r;
  logic [WIDTH-1:0] q2_r;

  // Capture stage followed by the settling stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_r <= {WIDTH{1'b0}};
      q2_r <= {WIDTH{1'b0}};
    end else begin
      q1_r <= d;
      q2_r <= q1_r;
    end
  end

  assign q = q2_r;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/full controller of the asynchronous FIFO.
// Define FIFO_OVERFLOW_FLAG_EN to add the sticky woverflow output.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = DEFAULT_ADDRSIZE,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wptr_full_if.slave   wif
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic              wfull_r;
  logic              walmost_full_r;
  logic [ADDRSIZE:0] wlevel_r;

  logic [ADDRSIZE:0] wq2_rptr_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] full_cmp_s;
  logic              wpush_s;
  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] level_next_s;

  fifo_sync_2ff #(.WIDTH(PW)) u_sync_rptr (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (wif.wrptr),
    .q     (wq2_rptr_s)
  );

  // Read pointer advanced by DEPTH: in Gray code that flips the two MSBs
  generate
    if (ADDRSIZE == 1) begin : g_full_cmp_narrow
      assign full_cmp_s = ~wq2_rptr_s;
    end else begin : g_full_cmp_wide
      assign full_cmp_s = {~wq2_rptr_s[ADDRSIZE:ADDRSIZE-1], wq2_rptr_s[ADDRSIZE-2:0]};
    end
  endgenerate

  // Next-state pointer and occupancy; write and read advance are folded into one subtraction
  always_comb begin
    wpush_s      = wif.winc & ~wfull_r;
    wbinnext_s   = wbin_r + PW'(wpush_s);
    wgraynext_s  = PW'(bin2gray(FUNC_W'(wbinnext_s)));
    rbin_s       = PW'(gray2bin(FUNC_W'(wq2_rptr_s)));
    level_next_s = wbinnext_s - rbin_s;
  end

  // Pointer and flag registers; flags only clear after the synchronised read pointer catches up
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_r         <= {PW{1'b0}};
      wptr_r         <= {PW{1'b0}};
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= {PW{1'b0}};
    end else begin
      wbin_r         <= wbinnext_s;
      wptr_r         <= wgraynext_s;
      wfull_r        <= (wgraynext_s == full_cmp_s);
      walmost_full_r <= (level_next_s >= AFULL_THRESH);
      wlevel_r       <= level_next_s;
    end
  end

`ifdef FIFO_OVERFLOW_FLAG_EN
  logic woverflow_r;

  // Sticky record of any write attempted while full
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      woverflow_r <= 1'b0;
    end else if (wif.winc && wfull_r) begin
      woverflow_r <= 1'b1;
    end else begin
      woverflow_r <= woverflow_r;
    end
  end

  assign wif.woverflow = woverflow_r;
`endif

  assign wif.waddr        = wbin_r[ADDRSIZE-1:0];
  assign wif.wptr         = wptr_r;
  assign wif.wfull        = wfull_r;
  assign wif.walmost_full = walmost_full_r;
  assign wif.wlevel       = wlevel_r;

endmodule
